decoder2_4_hold: RTL and testbench
==================================

# decoder2_4_hold

Registered binary-to-one-hot decoder with hold timing, the complement of the team's 4:2 priority encoder. It accepts a W-bit code through a valid/ready handshake and drives the matching one-hot line of a 2^W-bit output for HOLD clock cycles. Back-to-back codes are accepted without a gap. It sits between control logic that produces binary select codes and downstream one-hot strobes, such as enables, row selects or mux selects.

## Interface
Parameters:
- W, 2, code width; the output is N = 2^W bits wide.
- HOLD, 3, cycles each decoded output is held; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i  input  W  binary code.
- i_valid  input  1  code present on i.
- i_ready  output  1  block accepts i this cycle.
- clr  input  1  synchronous abort of the current hold.
- o  output  N  one-hot decoded output, registered.
- o_valid  output  1  o carries a decoded code.
- err  output  1  sticky consistency error (see Configuration).

## Operation
- A transfer occurs when i_valid && i_ready are both high on a rising clk edge.
- State IDLE:
  - i_ready = !clr.
  - On a transfer: o <= 1 << i, o_valid <= 1, code register <= i, cnt <= HOLD-1, next state ACTIVE.
- State ACTIVE:
  - o stays constant.
  - cnt decrements each cycle.
  - i_ready = (cnt == 0) && !clr.
- At cnt == 0 in ACTIVE:
  - With a transfer: load the new code, reload cnt = HOLD-1, remain in ACTIVE. There is no idle cycle between codes.
  - Without a transfer: o <= 0, o_valid <= 0, next state IDLE.
- clr high in any state: next cycle o = 0, o_valid = 0, cnt = 0, state IDLE. clr overrides i_valid, which is ignored while clr is high.
- HOLD = 1: cnt is always 0. i_ready is high every cycle (except during clr), and one code is consumed per cycle.
- Invariant: o is either all-zero with o_valid = 0, or exactly one-hot with o_valid = 1.
- Counter width: $clog2(HOLD) with a minimum of 1. cnt never wraps, because it is reloaded before it can underflow.

## Timing
- Reset values (asynchronous, applied immediately on rst_n low):
  - o = 0, o_valid = 0, cnt = 0, code register = 0, err = 0, state IDLE.
  - i_ready = 1 while in reset-released IDLE.
- Latency: output appears 1 cycle after the transfer edge.
- Each code is visible on o for exactly HOLD consecutive cycles, unless clr or reset intervenes.
- Reset asserted mid-hold: the output drops in the same cycle, with no wait for a clock edge.
- i_ready is combinational from state, cnt and clr. There is no combinational path from i_valid to i_ready.

## Configuration
- Macro: DECODER_CHECK_EN.
- When defined:
  - Each cycle that o_valid = 1, o is re-encoded with a highest-set-bit priority encoder.
  - The result is compared against the code register. o is also checked for one-hot.
  - Any mismatch sets err on the next edge. err stays high until reset.
- When undefined: the checker is not built and err is tied to 0. Port list is identical in both builds.

## Structure
- Package decoder_pkg:
  - state enum {IDLE, ACTIVE}.
  - function onehot(code), returning 1 << code sized N.
  - localparam rule for counter width.
- Sub-module prio_encoder (parameter W): combinational N-to-W highest-bit encoder, instantiated only under DECODER_CHECK_EN.

## Test plan
All scenarios use W = 2 and HOLD = 3 unless stated.
- Single code: i = 2'b10 with i_valid for 1 cycle at cycle 0.
  - Expect o = 4'b0100 and o_valid = 1 in cycles 1–3.
  - Expect i_ready = 0 in cycles 1–2 and 1 in cycle 3.
  - Expect o = 0 in cycle 4.
- Back-to-back: i = 3, then i = 0 presented with i_valid held high.
  - Expect o = 4'b1000 for 3 cycles, then 4'b0001 for 3 cycles.
  - No zero cycle between the two codes.
- clr at cycle 2 of a hold, with i_valid = 1 and i = 1.
  - Expect o = 0 and o_valid = 0 in cycle 3, i_ready = 0 during clr, and no transfer.
- Reset mid-hold: drop rst_n between edges in cycle 2.
  - Expect o = 0 and o_valid = 0 immediately, and i_ready = 1 after release.
- HOLD = 1 streaming codes 0, 1, 2, 3.
  - Expect o = 0001, 0010, 0100, 1000 on consecutive cycles, with i_ready constantly 1.
- DECODER_CHECK_EN:
  - 1000 random codes: err stays 0.
  - Then force o[1] on while code = 3: err = 1 on the next edge and stays high until rst_n.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered 2:4 (W:2^W) hold decoder.
package decoder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Widest code the helpers support; callers narrow the result to their own N.
  localparam int MAX_W = 8;
  localparam int MAX_N = 1 << MAX_W;

  // Hold counter must reach HOLD-1; a HOLD of 1 or 2 still needs one bit.
  function automatic int cnt_width(input int hold);
    return ($clog2(hold) < 1) ? 1 : $clog2(hold);
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int unsigned code);
    return MAX_N'(1) << code;
  endfunction

endpackage

// File: rtl/decoder2_4_hold_prio_encoder.sv
// Highest-set-bit N-to-W encoder used by the consistency checker.
// Only compiled when DECODER_CHECK_EN is defined.
`ifdef DECODER_CHECK_EN
module prio_encoder #(
  parameter int W = 2
) (
  input  logic [(1<<W)-1:0] in,
  output logic [W-1:0]      out
);

  localparam int N = 1 << W;

  // Later (higher) bits overwrite earlier ones, so the top set bit wins.
  always_comb begin
    out = '0;
    for (int k = 0; k < N; k++) begin
      if (in[k]) out = W'(k);
    end
  end

endmodule
`endif

// File: rtl/decoder2_4_hold.sv
// Registered binary-to-one-hot decoder; each code is held on o for HOLD cycles.
// Optional re-encode consistency checker enabled by DECODER_CHECK_EN.
module decoder2_4_hold
  import decoder_pkg::*;
#(
  parameter int W    = 2,
  parameter int HOLD = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      i,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              clr,
  output logic [(1<<W)-1:0] o,
  output logic              o_valid,
  output logic              err
);

  localparam int N  = 1 << W;
  localparam int CW = cnt_width(HOLD);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   code_q, code_d;
  logic [N-1:0]   o_q, o_d;
  logic           o_valid_q, o_valid_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    i_ready   = 1'b0;

    if (clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      o_d       = '0;
      o_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          i_ready = 1'b1;
          if (i_valid) begin
            state_d   = ACTIVE;
            cnt_d     = CNT_RELOAD;
            code_d    = i;
            o_d       = N'(onehot(32'(i)));
            o_valid_d = 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt_q == '0) begin
            i_ready = 1'b1;
            // Reload straight from the last hold cycle so codes stream gap-free.
            if (i_valid) begin
              cnt_d     = CNT_RELOAD;
              code_d    = i;
              o_d       = N'(onehot(32'(i)));
              o_valid_d = 1'b1;
            end else begin
              state_d   = IDLE;
              o_d       = '0;
              o_valid_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      code_q    <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;

`ifdef DECODER_CHECK_EN
  logic [W-1:0] enc;
  logic         is_onehot;
  logic         err_q, err_d;

  prio_encoder #(.W(W)) u_prio_encoder (
    .in  (o_q),
    .out (enc)
  );

  assign is_onehot = (o_q != '0) && ((o_q & (o_q - N'(1))) == '0);

  always_comb begin
    err_d = err_q;
    if (o_valid_q && (!is_onehot || (enc != code_q))) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder2_4_hold.sv
// Self-checking bench for decoder2_4_hold: directed scenarios plus random
// traffic against a cycle-timeline reference model; HOLD=1 instance alongside.
module tb_decoder2_4_hold;

  localparam int W    = 2;
  localparam int N    = 4;
  localparam int HOLD = 3;
  localparam int LEN  = 2048;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] i, i1;
  logic         i_valid, i_valid1, clr, clr1;
  logic         i_ready, i_ready1;
  logic [N-1:0] o, o1;
  logic         o_valid, o_valid1, err, err1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  // Code expected on o in each cycle (-1 = output idle).
  int exp_code [LEN];

  always #5 clk = ~clk;

  decoder2_4_hold #(.W(W), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .clr(clr), .o(o), .o_valid(o_valid), .err(err)
  );

  decoder2_4_hold #(.W(W), .HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i(i1), .i_valid(i_valid1), .i_ready(i_ready1),
    .clr(clr1), .o(o1), .o_valid(o_valid1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_o(input int c);
    return (exp_code[c] < 0) ? 32'd0 : (32'd1 << exp_code[c]);
  endfunction

  task automatic model_clear(input int from);
    for (int k = from; k < LEN; k++) exp_code[k] = -1;
  endtask

  // One clock cycle on the HOLD=3 instance: check ready, advance, check outputs.
  task automatic step(input int code, input bit v, input bit c);
    bit rdy;
    i = W'(code); i_valid = v; clr = c;
    #1;
    rdy = !c && (exp_code[cyc+1] < 0);
    chk("i_ready", 32'(i_ready), 32'(rdy));
    if (v && rdy) for (int k = 1; k <= HOLD; k++) exp_code[cyc+k] = code;
    if (c) model_clear(cyc + 1);
    @(posedge clk); #1;
    cyc++;
    chk("o", 32'(o), exp_o(cyc));
    chk("o_valid", 32'(o_valid), 32'(exp_code[cyc] >= 0));
    chk("err", 32'(err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; i = '0; i_valid = 1'b0; clr = 1'b0;
    i1 = '0; i_valid1 = 1'b0; clr1 = 1'b0;
    model_clear(0);
    #12;
    chk("reset_o", 32'(o), 32'd0);
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_i_ready", 32'(i_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc = 0;

    // single code 2: o=0100 for three cycles, ready only on the last
    step(2, 1, 0);
    chk("single_o_c1", 32'(o), 32'h4);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("single_o_c3", 32'(o), 32'h4);
    step(0, 0, 0);
    chk("single_o_c4", 32'(o), 32'h0);
    step(0, 0, 0);

    // back-to-back 3 then 0, no gap
    step(3, 1, 0);
    chk("b2b_first", 32'(o), 32'h8);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("b2b_second", 32'(o), 32'h1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("b2b_end", 32'(o), 32'h0);

    // clr in cycle 2 of a hold with a code pending
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    chk("clr_o", 32'(o), 32'h0);
    chk("clr_o_valid", 32'(o_valid), 32'd0);
    step(0, 0, 0);

    // reset between edges in cycle 2 of a hold
    step(2, 1, 0);
    step(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_o", 32'(o), 32'h0);
    chk("rst_mid_o_valid", 32'(o_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc++;
    model_clear(0);
    chk("rst_rel_i_ready", 32'(i_ready), 32'd1);

    // random traffic
    for (int n = 0; n < 1000; n++)
      step($urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

    // HOLD=1 streaming
    step(0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      e = 32'd1 << k;
      i1 = W'(k); i_valid1 = 1'b1;
      #1;
      chk("h1_i_ready", 32'(i_ready1), 32'd1);
      @(posedge clk); #1;
      chk("h1_o", 32'(o1), e);
      chk("h1_o_valid", 32'(o_valid1), 32'd1);
    end
    i_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("h1_idle", 32'(o1), 32'h0);
    cyc++;
    model_clear(0);

`ifdef DECODER_CHECK_EN
    step(3, 1, 0);
    force dut.o_q = 4'b1010;
    @(posedge clk); #1;
    chk("chk_err_set", 32'(err), 32'd1);
    release dut.o_q;
    i_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("chk_err_sticky", 32'(err), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("chk_err_reset", 32'(err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
